// File: rtl/output_backprop.sv
// output_backprop: serial one-weight-per-cycle gradient step on the 8 output-layer weights.
module output_backprop #(
    parameter int          LR_SHIFT = 4,
    parameter logic [7:0]  W_INIT   = 8'd64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  target_i,
    input  logic [22:0] final_i,
    input  logic [9:0]  x0_i,
    input  logic [9:0]  x1_i,
    input  logic [9:0]  x2_i,
    input  logic [9:0]  x3_i,
    input  logic [9:0]  x4_i,
    input  logic [9:0]  x5_i,
    input  logic [9:0]  x6_i,
    input  logic [9:0]  x7_i,
    output logic [7:0]  w0_o,
    output logic [7:0]  w1_o,
    output logic [7:0]  w2_o,
    output logic [7:0]  w3_o,
    output logic [7:0]  w4_o,
    output logic [7:0]  w5_o,
    output logic [7:0]  w6_o,
    output logic [7:0]  w7_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  upd_cnt_o
);
    typedef enum logic [1:0] {IDLE, LATCH, UPDATE, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0]         w_q [8];
    logic [9:0]         x_q [8];
    logic [9:0]         x_in [8];
    logic signed [23:0] err_q, err_d;
    logic [2:0]         idx_q;
    logic [7:0]         cnt_q;
    logic signed [34:0] prod, delta;
    logic signed [35:0] wn;
    logic [7:0]         w_new;

    assign x_in = '{x0_i, x1_i, x2_i, x3_i, x4_i, x5_i, x6_i, x7_i};

    always_comb begin
        err_d = {1'b0, final_i} - {20'b0, target_i};
        state_d = state_q == IDLE   ? (start_i ? LATCH : IDLE) :
                  state_q == LATCH  ? (err_d == '0 ? DONE : UPDATE) :
                  state_q == UPDATE ? (idx_q == 3'd7 ? DONE : UPDATE) : IDLE;
    end

    // Product fits in 35 bits; sign-extend err, zero-extend x, then floor-shift.
    always_comb begin
        prod  = {{11{err_q[23]}}, err_q} * {25'b0, x_q[idx_q]};
        delta = prod >>> LR_SHIFT;
        wn    = {28'b0, w_q[idx_q]} - {delta[34], delta};
        w_new = wn[35] ? 8'd0 : (|wn[34:8]) ? 8'hff : wn[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            w_q   <= '{default: W_INIT};
            x_q   <= '{default: '0};
            err_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
        end else if (state_q == LATCH) begin
            err_q <= err_d;
            x_q   <= x_in;
            idx_q <= '0;
        end else if (state_q == UPDATE) begin
            w_q[idx_q] <= w_new;
            idx_q      <= idx_q + 3'd1;
            if (idx_q == 3'd7 && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
        end
    end

    assign w0_o      = w_q[0];
    assign w1_o      = w_q[1];
    assign w2_o      = w_q[2];
    assign w3_o      = w_q[3];
    assign w4_o      = w_q[4];
    assign w5_o      = w_q[5];
    assign w6_o      = w_q[6];
    assign w7_o      = w_q[7];
    assign busy_o    = state_q != IDLE;
    assign done_o    = state_q == DONE;
    assign upd_cnt_o = cnt_q;
endmodule
